// File: rtl/reorder_buffer.sv
// Purpose: 8-entry in-order-commit reorder buffer with rename-aware busy clear and mispredict flush.
// Latency: result captured at edge N commits at edge N+1 at the earliest; commit/flush outputs are registered.
// Backpressure: full refuses issue (issuer stalls); rdy=0 freezes all state; clear cycle drops issue/writeback.
module reorder_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic        issue_is_branch,
    output logic [31:0] alloc_tag,
    output logic        full,
    input  logic        wb_valid,
    input  logic [31:0] wb_tag,
    input  logic [31:0] wb_value,
    input  logic        wb_mispredict,
    input  logic [31:0] wb_target,
    output logic        commit_reg_we,
    output logic [31:0] commit_rd,
    output logic [31:0] commit_data,
    output logic [31:0] commit_tag,
    input  logic        rd_busy_cur,
    input  logic [31:0] rd_tag_cur,
    output logic        commit_busy_we,
    output logic        commit_busy_next,
    output logic        clear,
    output logic [31:0] redirect_pc
);

    typedef struct packed {
        logic        valid;
        logic        ready;
        logic        is_branch;
        logic        mispredict;
        logic [4:0]  rd;
        logic [31:0] value;
        logic [31:0] target;
    } entry_t;

    entry_t     ent [8];
    logic [2:0] head;
    logic [2:0] tail;
    logic [3:0] count;

    logic       head_done;
    logic       do_flush;
    logic       do_commit;
    logic       commit_writes;
    logic       do_issue;
    logic [2:0] wb_idx;
    logic       wb_hit;
    logic       unused_wb_tag_hi;

    assign full      = (count == 4'd8);
    assign alloc_tag = {29'd0, tail};

    // Only the low three tag bits address an entry.
    assign wb_idx           = wb_tag[2:0];
    assign unused_wb_tag_hi = ^wb_tag[31:3];

    // Head retires once its result has arrived; a mispredicted branch turns the retire into a flush.
    assign head_done     = ent[head].valid && ent[head].ready;
    assign do_flush      = head_done && ent[head].is_branch && ent[head].mispredict;
    assign do_commit     = head_done && !do_flush;
    assign commit_writes = (ent[head].rd != 5'd0) && !ent[head].is_branch;

    // full uses the pre-edge count, so a full buffer refuses issue even while it commits.
    assign do_issue = issue_valid && !full;
    assign wb_hit   = wb_valid && ent[wb_idx].valid;

    // Busy bit is released only when no younger instruction has renamed the same register.
    assign commit_busy_we   = commit_reg_we && rd_busy_cur && (rd_tag_cur == commit_tag);
    assign commit_busy_next = 1'b0;

    // Entry table, pointers and registered commit/flush outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].ready <= 1'b0;
            end
            head          <= 3'd0;
            tail          <= 3'd0;
            count         <= 4'd0;
            commit_reg_we <= 1'b0;
            commit_rd     <= 32'd0;
            commit_data   <= 32'd0;
            commit_tag    <= 32'd0;
            clear         <= 1'b0;
            redirect_pc   <= 32'd0;
        end else if (!rdy) begin
            commit_reg_we <= 1'b0;
            clear         <= 1'b0;
        end else if (clear) begin
            // Flush cycle: the table was already emptied at the previous edge.
            commit_reg_we <= 1'b0;
            clear         <= 1'b0;
        end else if (do_flush) begin
            for (int i = 0; i < 8; i++) begin
                ent[i].valid <= 1'b0;
                ent[i].ready <= 1'b0;
            end
            head          <= 3'd0;
            tail          <= 3'd0;
            count         <= 4'd0;
            commit_reg_we <= 1'b0;
            clear         <= 1'b1;
            redirect_pc   <= ent[head].target;
        end else begin
            commit_reg_we <= 1'b0;
            if (wb_hit) begin
                ent[wb_idx].ready      <= 1'b1;
                ent[wb_idx].value      <= wb_value;
                ent[wb_idx].mispredict <= wb_mispredict;
                ent[wb_idx].target     <= wb_target;
            end
            // Retire after the writeback so that the popped head ends up invalid.
            if (do_commit) begin
                ent[head].valid <= 1'b0;
                ent[head].ready <= 1'b0;
                head            <= head + 3'd1;
                if (commit_writes) begin
                    commit_reg_we <= 1'b1;
                    commit_rd     <= {27'd0, ent[head].rd};
                    commit_data   <= ent[head].value;
                    commit_tag    <= {29'd0, head};
                end
            end
            // tail never aliases the head or a writeback target here: that would need a full buffer.
            if (do_issue) begin
                ent[tail].valid     <= 1'b1;
                ent[tail].ready     <= 1'b0;
                ent[tail].rd        <= issue_rd;
                ent[tail].is_branch <= issue_is_branch;
                tail                <= tail + 3'd1;
            end
            count <= count + {3'd0, do_issue} - {3'd0, do_commit};
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Purpose: directed and randomized checks of reorder_buffer against a queue-based reference model.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises full, rdy=0 stalls and flush cycles.
module tb_reorder_buffer;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_is_branch;
    logic [31:0] alloc_tag;
    logic        full;
    logic        wb_valid;
    logic [31:0] wb_tag;
    logic [31:0] wb_value;
    logic        wb_mispredict;
    logic [31:0] wb_target;
    logic        commit_reg_we;
    logic [31:0] commit_rd;
    logic [31:0] commit_data;
    logic [31:0] commit_tag;
    logic        rd_busy_cur;
    logic [31:0] rd_tag_cur;
    logic        commit_busy_we;
    logic        commit_busy_next;
    logic        clear;
    logic [31:0] redirect_pc;

    reorder_buffer dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .issue_valid      (issue_valid),
        .issue_rd         (issue_rd),
        .issue_is_branch  (issue_is_branch),
        .alloc_tag        (alloc_tag),
        .full             (full),
        .wb_valid         (wb_valid),
        .wb_tag           (wb_tag),
        .wb_value         (wb_value),
        .wb_mispredict    (wb_mispredict),
        .wb_target        (wb_target),
        .commit_reg_we    (commit_reg_we),
        .commit_rd        (commit_rd),
        .commit_data      (commit_data),
        .commit_tag       (commit_tag),
        .rd_busy_cur      (rd_busy_cur),
        .rd_tag_cur       (rd_tag_cur),
        .commit_busy_we   (commit_busy_we),
        .commit_busy_next (commit_busy_next),
        .clear            (clear),
        .redirect_pc      (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: program-order list of in-flight instructions.
    typedef struct {
        logic [2:0]  tag;
        logic [4:0]  rd;
        logic        br;
        logic        done;
        logic [31:0] value;
        logic        misp;
        logic [31:0] target;
    } rec_t;

    rec_t        q[$];
    int          next_tag;
    logic        m_we;
    logic [31:0] m_rd;
    logic [31:0] m_data;
    logic [31:0] m_tag;
    logic        m_clear;
    logic [31:0] m_pc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        rec_t r;
        bit   was_full;
        if (rst) begin
            q.delete();
            next_tag = 0;
            m_we = 0; m_rd = 0; m_data = 0; m_tag = 0; m_clear = 0; m_pc = 0;
        end else if (!rdy) begin
            m_we = 0;
            m_clear = 0;
        end else if (m_clear) begin
            m_we = 0;
            m_clear = 0;
        end else begin
            was_full = (q.size() == 8);
            m_we = 0;
            if (q.size() > 0 && q[0].done && q[0].br && q[0].misp) begin
                m_clear = 1;
                m_pc = q[0].target;
                q.delete();
                next_tag = 0;
            end else begin
                if (q.size() > 0 && q[0].done) begin
                    r = q.pop_front();
                    if (r.rd != 0 && !r.br) begin
                        m_we = 1;
                        m_rd = 32'(r.rd);
                        m_data = r.value;
                        m_tag = 32'(r.tag);
                    end
                end
                if (wb_valid) begin
                    for (int i = 0; i < q.size(); i++) begin
                        if (q[i].tag == wb_tag[2:0]) begin
                            r = q[i];
                            r.done = 1; r.value = wb_value; r.misp = wb_mispredict; r.target = wb_target;
                            q[i] = r;
                        end
                    end
                end
                if (issue_valid && !was_full) begin
                    r.tag = 3'(next_tag); r.rd = issue_rd; r.br = issue_is_branch;
                    r.done = 0; r.value = 0; r.misp = 0; r.target = 0;
                    q.push_back(r);
                    next_tag = (next_tag + 1) % 8;
                end
            end
        end
    endtask

    task automatic check_outputs();
        chk("reg_we", commit_reg_we, m_we);
        chk("commit_rd", commit_rd, m_rd);
        chk("commit_data", commit_data, m_data);
        chk("commit_tag", commit_tag, m_tag);
        chk("clear", clear, m_clear);
        chk("redirect_pc", redirect_pc, m_pc);
        chk("full", full, q.size() == 8);
        chk("alloc_tag", alloc_tag, 32'(next_tag));
        chk("busy_we", commit_busy_we, m_we && rd_busy_cur && (rd_tag_cur == m_tag));
        chk("busy_next", commit_busy_next, 0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        issue_valid = 0; wb_valid = 0; wb_mispredict = 0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic br);
        issue_valid = 1; issue_rd = rd; issue_is_branch = br; wb_valid = 0;
    endtask

    task automatic wb(input int tag, input logic [31:0] val, input logic misp, input logic [31:0] tgt);
        issue_valid = 0; wb_valid = 1; wb_tag = 32'(tag); wb_value = val;
        wb_mispredict = misp; wb_target = tgt;
    endtask

    task automatic do_reset();
        idle();
        rst = 1; rdy = 1;
        cycle();
        rst = 0;
    endtask

    initial begin
        rst = 1; rdy = 1; idle();
        issue_rd = 0; issue_is_branch = 0; wb_tag = 0; wb_value = 0; wb_target = 0;
        rd_busy_cur = 0; rd_tag_cur = 0;
        #1;
        do_reset();
        chk("rst_alloc", alloc_tag, 0);
        chk("rst_full", full, 0);

        // Single ALU result commits one edge after capture and releases its busy bit.
        issue(5, 0); cycle();
        wb(0, 32'hDEAD, 0, 0); cycle();
        rd_busy_cur = 1; rd_tag_cur = 0;
        idle(); cycle();
        chk("s1_we", commit_reg_we, 1);
        chk("s1_rd", commit_rd, 5);
        chk("s1_data", commit_data, 32'hDEAD);
        chk("s1_busy", commit_busy_we, 1);
        cycle();
        chk("s1_we_pulse", commit_reg_we, 0);

        // Younger rename of the same register keeps the busy bit.
        do_reset();
        issue(3, 0); cycle();
        issue(3, 0); cycle();
        wb(0, 32'h11, 0, 0); cycle();
        rd_tag_cur = 1;
        idle(); cycle();
        chk("s2_we", commit_reg_we, 1);
        chk("s2_busy", commit_busy_we, 0);
        wb(1, 32'h22, 0, 0); cycle();
        idle(); cycle();
        chk("s2_busy_young", commit_busy_we, 1);

        // Fill, overflow, reverse-order completion, in-order drain and wrap.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            issue(5'(i + 1), 0);
            chk("s3_alloc", alloc_tag, i);
            cycle();
        end
        chk("s3_full", full, 1);
        issue(9, 0); cycle();
        chk("s3_full_hold", full, 1);
        chk("s3_alloc_wrap", alloc_tag, 0);
        for (int k = 7; k >= 0; k--) begin
            wb(k, 32'h100 + 32'(k), 0, 0); cycle();
            chk("s3_no_early", commit_reg_we, 0);
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            cycle();
            chk("s3_we", commit_reg_we, 1);
            chk("s3_tag", commit_tag, i);
            chk("s3_data", commit_data, 32'h100 + 32'(i));
        end
        chk("s3_empty_full", full, 0);
        chk("s3_alloc_again", alloc_tag, 0);
        issue(1, 0); cycle();
        chk("s3_alloc_next", alloc_tag, 1);

        // Mispredicted branch flushes after older commits and discards younger work.
        do_reset();
        issue(1, 0); cycle();
        issue(2, 0); cycle();
        issue(0, 1); cycle();
        issue(4, 0); cycle();
        wb(0, 32'hA0, 0, 0); cycle();
        wb(1, 32'hA1, 0, 0); cycle();
        chk("s4_c0", commit_tag, 0);
        wb(2, 0, 1, 32'h1000); cycle();
        chk("s4_c1", commit_tag, 1);
        idle(); cycle();
        chk("s4_clear", clear, 1);
        chk("s4_pc", redirect_pc, 32'h1000);
        chk("s4_full", full, 0);
        chk("s4_alloc", alloc_tag, 0);
        issue(7, 0); cycle();
        chk("s4_clear_pulse", clear, 0);
        chk("s4_issue_dropped", alloc_tag, 0);
        issue(7, 0); cycle();
        wb(0, 32'h77, 0, 0); cycle();
        idle(); cycle();
        chk("s4_post_tag", commit_tag, 0);
        chk("s4_post_data", commit_data, 32'h77);

        // Stall holds a ready head; reset mid-operation clears everything.
        do_reset();
        issue(6, 0); cycle();
        wb(0, 32'h66, 0, 0); cycle();
        idle(); rdy = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("s5_stall", commit_reg_we, 0);
        end
        rdy = 1; cycle();
        chk("s5_release", commit_reg_we, 1);
        chk("s5_rd", commit_rd, 6);
        for (int i = 0; i < 5; i++) begin
            issue(5'(i + 1), 0); cycle();
        end
        idle(); rst = 1; rdy = 0; cycle(); rst = 0; rdy = 1;
        chk("s5_rst_we", commit_reg_we, 0);
        chk("s5_rst_rd", commit_rd, 0);
        chk("s5_rst_data", commit_data, 0);
        chk("s5_rst_tag", commit_tag, 0);
        chk("s5_rst_alloc", alloc_tag, 0);

        // Randomized traffic.
        for (int n = 0; n < 1500; n++) begin
            rst             = ($urandom_range(0, 99) == 0);
            rdy             = ($urandom_range(0, 9) != 0);
            issue_valid     = ($urandom_range(0, 2) != 0);
            issue_is_branch = ($urandom_range(0, 4) == 0);
            issue_rd        = issue_is_branch ? 5'd0 : 5'($urandom_range(0, 31));
            wb_valid        = ($urandom_range(0, 2) != 0);
            wb_tag          = {$urandom} & 32'hFFFF_FFF8 | 32'($urandom_range(0, 7));
            wb_value        = $urandom;
            wb_mispredict   = ($urandom_range(0, 5) == 0);
            wb_target       = $urandom;
            rd_busy_cur     = $urandom_range(0, 1);
            rd_tag_cur      = 32'($urandom_range(0, 7));
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 SHALL have the following ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global ready; low freezes all state.
- issue_valid  in  1  allocate one entry this cycle.
- issue_rd  in  5  destination register; 0 = none (branch/store).
- issue_is_branch  in  1  entry is a branch.
- alloc_tag  out  32  index of the entry allocated on an accepted issue, zero-extended, combinational (= tail).
- full  out  1  combinational, count==8.
- wb_valid  in  1  result broadcast valid.
- wb_tag  in  32  entry index of the result; bits [2:0] used.
- wb_value  in  32  result data.
- wb_mispredict  in  1  branch resolved against prediction.
- wb_target  in  32  correct PC on mispredict.
- commit_reg_we  out  1  register-file data write strobe, registered.
- commit_rd  out  32  committed destination register, zero-extended, registered.
- commit_data  out  32  committed value, registered.
- commit_tag  out  32  committed entry index, registered.
- rd_busy_cur  in  1  register-file busy bit for commit_rd, combinational.
- rd_tag_cur  in  32  register-file rename tag for commit_rd, combinational.
- commit_busy_we  out  1  busy-bit update strobe, combinational.
- commit_busy_next  out  1  busy value to write; constant 0.
- clear  out  1  pipeline flush, registered, one-cycle pulse.
- redirect_pc  out  32  fetch redirect PC, valid while clear=1.

Function
REQ-002 SHALL hold 8 entries in a circular buffer with a 3-bit head, a 3-bit tail and a 4-bit count. Each entry holds valid, ready, rd, is_branch, value, mispredict and target.
REQ-003 On issue_valid && !full && !clear, SHALL write entry[tail] as {valid=1, ready=0, rd, is_branch}, advance tail (7 wraps to 0) and increment count.
REQ-004 On issue_valid while full, SHALL ignore the request with no state change; the issuer must stall.
REQ-005 On wb_valid && entry[wb_tag[2:0]].valid && !clear, SHALL set ready=1 and capture value, mispredict and target.
- A writeback to an invalid entry SHALL be ignored.
REQ-006 Commit SHALL occur when the head entry is valid and ready at a posedge: pop head, advance head, decrement count. Maximum one commit per cycle.
REQ-007 When a committing entry has rd!=0 and is_branch=0, SHALL register commit_reg_we=1, commit_rd, commit_data and commit_tag=head for exactly one cycle. Otherwise commit_reg_we=0.
REQ-008 SHALL compute commit_busy_we = commit_reg_we && rd_busy_cur && (rd_tag_cur==commit_tag). This clears busy only if no younger rename of commit_rd exists.
REQ-009 Writeback-to-commit latency: a result captured at edge N is committed at edge N+1 at the earliest. commit_reg_we is high during cycle N+1..N+2.
REQ-010 Issue and commit in the same cycle SHALL both take effect; count is unchanged. full is evaluated on the pre-edge count, so a full buffer refuses issue even when committing that cycle.
REQ-011 If the committing head has is_branch && mispredict, SHALL register clear=1 and redirect_pc=target for one cycle. At the same edge it SHALL invalidate all entries and set head=tail=count=0.
REQ-012 While clear=1, issue_valid and wb_valid SHALL be ignored and no commit occurs.
REQ-013 With rdy=0, SHALL hold all state, drive commit_reg_we=0 and clear=0, and suppress allocation, writeback and commit.

Reset
REQ-014 On rst=1 at a posedge, SHALL set all entries invalid and head=tail=count=0. Outputs SHALL be commit_reg_we=0, commit_rd/data/tag=0, clear=0, redirect_pc=0, full=0, alloc_tag=0.
REQ-015 rst SHALL take priority over rdy, clear, issue, writeback and commit, including mid-operation with a full buffer.

Verification
REQ-016 Issue rd=5 (tag 0), wb tag0 value 0xDEAD, rd_tag_cur=0, rd_busy_cur=1 -> next cycle commit_reg_we=1, commit_rd=5, commit_data=0xDEAD, commit_busy_we=1.
REQ-017 Issue rd=3 twice (tags 0, 1), complete tag0, rd_tag_cur=1 -> commit_reg_we=1, commit_busy_we=0.
REQ-018 Issue 8 entries -> full=1, 9th issue ignored. Complete all out of order (7..0) -> commits in order 0..7, one per cycle. Issue again -> alloc_tag=0 after wrap.
REQ-019 Issue branch (tag 2 after two ALU ops), complete all, branch mispredict target 0x1000 -> two commits, then clear=1 with redirect_pc=0x1000 for one cycle, count=0, full=0. A younger issued entry is discarded.
REQ-020 Hold rdy=0 with the head ready for 3 cycles -> no commit. Release -> commit on the next edge. Assert rst with 5 entries pending -> all outputs 0, subsequent alloc_tag=0.
